// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 16-bit ALU across NUM_REQ requesters with a 2-stage pipeline.
// Optional macro ALU_ARB_PRIO0_EN gives requester 0 fixed highest priority.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  output logic [3:0]              alu_op,
  input  logic [15:0]             alu_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_result,
  output logic                    rsp_err,
  output logic                    busy
);
  logic [IDX_W-1:0] ptr, gnt, j, s1_idx;
  logic found, upd, xfer, s1_valid, s1_err;
  logic [15:0] sel_a, sel_b;
  logic [3:0] sel_op;
  // scan downward so the last hit is the one nearest ptr+1
  always_comb begin
    gnt = '0;
    j = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[j]) begin
        gnt = j;
        found = 1'b1;
      end
    end
    upd = found;
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt = '0;
      upd = 1'b0;
    end
`endif
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt == IDX_W'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
        sel_op = req_op[4*i +: 4];
      end
  end
  assign req_ready = (en && found && !rst) ? NUM_REQ'(1) << gnt : '0;
  assign xfer = |(req_valid & req_ready);
  assign busy = s1_valid | (|rsp_valid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= IDX_W'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_idx <= '0;
      s1_err <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= 4'b0110;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        alu_a <= sel_a;
        alu_b <= sel_b;
        alu_op <= sel_op;
        s1_idx <= gnt;
        s1_err <= sel_op > 4'b1100;
        if (upd) ptr <= gnt;
      end
      rsp_valid <= s1_valid ? NUM_REQ'(1) << s1_idx : '0;
      rsp_err <= s1_valid & s1_err;
      if (s1_valid) rsp_result <= s1_err ? 16'h0000 : alu_result;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level model with per-cycle compare plus directed literal checks.
module tb_alu_arbiter;
  localparam int N = 4;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd4;
  logic clk = 0, rst = 1, en = 0;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [4*N-1:0] req_op;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0] alu_op;
  logic rsp_err, busy;
  int n_chk = 0, n_fail = 0, cyc_n = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // stand-in ALU: saturating add/sub; illegal opcodes yield a marker the arbiter must suppress
  function automatic logic [15:0] alu_fn(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0: return s[16] ? 16'hFFFF : s[15:0];
      4'd1: return a < b ? 16'h0000 : a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd6: return 16'h0000;
      default: return op > 4'd12 ? 16'hDEAD : a;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  typedef struct { int due; int idx; logic [15:0] res; logic err; } rsp_t;
  rsp_t q[$];
  int m_ptr = N - 1;
  logic [15:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0] m_op = 4'b0110;

  // model: grant by rotating search, response due two cycles after the grant cycle
  initial forever begin
    int g;
    logic [N-1:0] rv_e;
    logic err_e, busy_e;
    logic [3:0] op;
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_ptr = N - 1;
      m_a = 0; m_b = 0; m_op = 4'b0110; m_res = 0;
    end
    g = -1;
    if (!rst && en) begin
`ifdef ALU_ARB_PRIO0_EN
      if (req_valid[0]) g = 0;
`endif
      if (g < 0)
        for (int k = 1; k <= N; k++)
          if (req_valid[(m_ptr + k) % N]) begin
            g = (m_ptr + k) % N;
            break;
          end
    end
    busy_e = q.size() != 0;
    rv_e = 0;
    err_e = 0;
    if (q.size() != 0 && q[0].due == cyc_n) begin
      rv_e = N'(1) << q[0].idx;
      err_e = q[0].err;
      m_res = q[0].res;
      void'(q.pop_front());
    end
    chk("m_ready", req_ready, g < 0 ? 0 : N'(1) << g);
    chk("m_rsp_valid", rsp_valid, rv_e);
    chk("m_rsp_err", rsp_err, err_e);
    chk("m_rsp_result", rsp_result, m_res);
    chk("m_busy", busy, busy_e);
    chk("m_alu", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
    if (g >= 0) begin
      op = req_op[4*g +: 4];
      m_a = req_a[16*g +: 16];
      m_b = req_b[16*g +: 16];
      m_op = op;
      q.push_back('{cyc_n + 2, g, op > 4'd12 ? 16'h0000 : alu_fn(op, m_a, m_b), op > 4'd12});
`ifdef ALU_ARB_PRIO0_EN
      if (g != 0) m_ptr = g;
`else
      m_ptr = g;
`endif
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic put(int i, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    req_valid[i] = 1'b1;
    req_op[4*i +: 4] = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  logic [3:0] gt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
    cyc;
    req_valid = '1;
    en = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_alu_op", alu_op, 4'b0110);
    chk("rst_alu_ab", {alu_a, alu_b}, 0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_err, busy}, 0);
    cyc;
    req_valid = 0;
    rst = 0;
    put(1, ADD, 16'h1234, 16'h4321);
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0010);
    cyc;
    req_valid[1] = 0;
    @(negedge clk);
    chk("single_busy", busy, 1);
    chk("single_early", rsp_valid, 0);
    cyc;
    @(negedge clk);
    chk("single_rsp", {rsp_valid, rsp_result, rsp_err}, {4'b0010, 16'h5555, 1'b0});
    cyc;
    put(2, SUB, 16'h000D, 16'h000F);
    @(negedge clk);
    chk("sat_ready", req_ready, 4'b0100);
    cyc;
    put(2, ADD, 16'hFFFE, 16'h000F);
    @(negedge clk);
    chk("sat_ready2", req_ready, 4'b0100);
    cyc;
    req_valid[2] = 0;
    @(negedge clk);
    chk("sat_sub", {rsp_valid, rsp_result}, {4'b0100, 16'h0000});
    cyc;
    @(negedge clk);
    chk("sat_add", {rsp_valid, rsp_result}, {4'b0100, 16'hFFFF});
    cyc;
    put(3, 4'hF, 16'h1111, 16'h2222);
    @(negedge clk);
    chk("ill_ready", req_ready, 4'b1000);
    cyc;
    for (int i = 0; i < N; i++) put(i, XOR, 16'h6F3A, 16'h299F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifndef ALU_ARB_PRIO0_EN
      chk("fair_grant", req_ready, gt[k]);
      if (k >= 2) chk("fair_rsp_to", rsp_valid, gt[k-2]);
`endif
      if (k == 1) chk("ill_rsp", {rsp_valid, rsp_result, rsp_err}, {4'b1000, 16'h0000, 1'b1});
      if (k >= 2) chk("fair_rsp", {rsp_result, rsp_err}, {16'h46A5, 1'b0});
      cyc;
    end
    en = 0;
    @(negedge clk);
    chk("en_ready", req_ready, 0);
    chk("en_rsp1", {rsp_result, busy}, {16'h46A5, 1'b1});
`ifndef ALU_ARB_PRIO0_EN
    chk("en_rsp1_to", rsp_valid, 4'b0001);
`endif
    cyc;
    @(negedge clk);
    chk("en_ready2", req_ready, 0);
    chk("en_rsp2", {rsp_result, busy}, {16'h46A5, 1'b1});
`ifndef ALU_ARB_PRIO0_EN
    chk("en_rsp2_to", rsp_valid, 4'b0010);
`endif
    cyc;
    @(negedge clk);
    chk("en_drained", {rsp_valid, busy}, 0);
    cyc;
    en = 1;
    @(negedge clk);
`ifndef ALU_ARB_PRIO0_EN
    chk("pre_rst_grant", req_ready, 4'b0100);
`endif
    cyc;
    rst = 1;
    @(negedge clk);
    chk("mid_rst", {req_ready, rsp_valid, busy}, 0);
    cyc;
    @(negedge clk);
    chk("mid_rst2", {rsp_valid, busy}, 0);
    cyc;
    rst = 0;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    cyc;
    @(negedge clk);
`ifndef ALU_ARB_PRIO0_EN
    chk("post_rst_grant2", req_ready, 4'b0010);
`else
    chk("post_rst_grant2", req_ready, 4'b0001);
    cyc;
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("prio0_grant", req_ready, 4'b0001);
      cyc;
    end
    req_valid[0] = 0;
    @(negedge clk);
    chk("prio0_release", req_ready, 4'b0100);
`endif
    cyc;
    req_valid = 0;
    repeat (4) cyc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal;
  end
endmodule
